// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream from the UART receiver and the resulting command side effects
// (baud select, register write bus, frame status).
interface uart_cmd_ctrl_if;
    logic [7:0] Rx_Data;
    logic       Rx_Done;
    logic [2:0] Baud_set;
    logic       Reg_wr_en;
    logic [7:0] Reg_addr;
    logic [7:0] Reg_wdata;
    logic       Frame_ok;
    logic       Frame_err;
    logic [7:0] Frame_cnt;

    modport master (
        output Rx_Data, Rx_Done,
        input  Baud_set, Reg_wr_en, Reg_addr, Reg_wdata,
        input  Frame_ok, Frame_err, Frame_cnt
    );

    modport slave (
        input  Rx_Data, Rx_Done,
        output Baud_set, Reg_wr_en, Reg_addr, Reg_wdata,
        output Frame_ok, Frame_err, Frame_cnt
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: assembles HEADER/CMD/ADDR/DATA/CHK frames from
// received bytes, verifies the 8-bit sum and executes register writes or
// baud changes. An inter-byte timeout returns a stalled frame to IDLE.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | hunting for HEADER, other bytes dropped silently
// CMD    | waiting for command byte
// ADDR   | waiting for address byte
// DATA   | waiting for data byte
// CHK    | waiting for checksum byte, compare against running sum
// EXEC   | one cycle: apply command, incoming bytes are dropped
module uart_cmd_ctrl #(
    parameter logic [7:0] HEADER       = 8'hAA,
    parameter int         TIMEOUT_CYC  = 50000,
    parameter logic [2:0] BAUD_DEFAULT = 3'd4
) (
    input  logic          Clk,
    input  logic          Reset,
    uart_cmd_ctrl_if.slave bus
);

    localparam int             TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC
    } state_t;

    state_t        state_q, state_nxt;
    logic [7:0]    cmd_q, cmd_nxt;
    logic [7:0]    addr_q, addr_nxt;
    logic [7:0]    data_q, data_nxt;
    logic [7:0]    sum_q, sum_nxt;
    logic [TW-1:0] tmr_q, tmr_nxt;
    logic [2:0]    baud_q, baud_nxt;
    logic          wr_q, wr_nxt;
    logic          ok_q, ok_nxt;
    logic          err_q, err_nxt;
    logic [7:0]    raddr_q, raddr_nxt;
    logic [7:0]    rwdata_q, rwdata_nxt;
    logic [7:0]    cnt_q, cnt_nxt;
    logic          in_frame;
    logic          expired;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state, frame datapath and registered-output next values.
    always_comb begin
        state_nxt  = state_q;
        cmd_nxt    = cmd_q;
        addr_nxt   = addr_q;
        data_nxt   = data_q;
        sum_nxt    = sum_q;
        baud_nxt   = baud_q;
        wr_nxt     = 1'b0;
        ok_nxt     = 1'b0;
        err_nxt    = 1'b0;
        raddr_nxt  = raddr_q;
        rwdata_nxt = rwdata_q;
        cnt_nxt    = cnt_q;

        in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                   (state_q == S_DATA) || (state_q == S_CHK);
        // A byte on the expiry cycle takes priority over the timeout.
        expired  = in_frame && !bus.Rx_Done && (tmr_q == '0);

        if (!in_frame || bus.Rx_Done || expired) tmr_nxt = TMR_LOAD;
        else                                     tmr_nxt = tmr_q - 1'b1;

        if (expired) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Rx_Done && bus.Rx_Data == HEADER) begin
                        state_nxt = S_CMD;
                        sum_nxt   = 8'h00;
                    end
                end
                S_CMD: begin
                    if (bus.Rx_Done) begin
                        cmd_nxt   = bus.Rx_Data;
                        sum_nxt   = bus.Rx_Data;
                        state_nxt = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.Rx_Done) begin
                        addr_nxt  = bus.Rx_Data;
                        sum_nxt   = sum_q + bus.Rx_Data;
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.Rx_Done) begin
                        data_nxt  = bus.Rx_Data;
                        sum_nxt   = sum_q + bus.Rx_Data;
                        state_nxt = S_CHK;
                    end
                end
                S_CHK: begin
                    if (bus.Rx_Done) begin
                        if (bus.Rx_Data == sum_q) begin
                            state_nxt = S_EXEC;
                        end else begin
                            state_nxt = S_IDLE;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state_nxt = S_IDLE;
                    case (cmd_q)
                        8'h01: begin
                            wr_nxt     = 1'b1;
                            raddr_nxt  = addr_q;
                            rwdata_nxt = data_q;
                            ok_nxt     = 1'b1;
                            cnt_nxt    = cnt_q + 8'd1;
                        end
                        8'h02: begin
                            if (data_q <= 8'd4) begin
                                baud_nxt = data_q[2:0];
                                ok_nxt   = 1'b1;
                                cnt_nxt  = cnt_q + 8'd1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame registers, timeout timer and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            sum_q    <= 8'h00;
            tmr_q    <= TMR_LOAD;
            baud_q   <= BAUD_DEFAULT;
            wr_q     <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            raddr_q  <= 8'h00;
            rwdata_q <= 8'h00;
            cnt_q    <= 8'h00;
        end else begin
            cmd_q    <= cmd_nxt;
            addr_q   <= addr_nxt;
            data_q   <= data_nxt;
            sum_q    <= sum_nxt;
            tmr_q    <= tmr_nxt;
            baud_q   <= baud_nxt;
            wr_q     <= wr_nxt;
            ok_q     <= ok_nxt;
            err_q    <= err_nxt;
            raddr_q  <= raddr_nxt;
            rwdata_q <= rwdata_nxt;
            cnt_q    <= cnt_nxt;
        end
    end

    assign bus.Baud_set  = baud_q;
    assign bus.Reg_wr_en = wr_q;
    assign bus.Reg_addr  = raddr_q;
    assign bus.Reg_wdata = rwdata_q;
    assign bus.Frame_ok  = ok_q;
    assign bus.Frame_err = err_q;
    assign bus.Frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a short timeout.
module tb_uart_cmd_ctrl;

    localparam int T = 20;

    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;
    int   wr_count = 0;
    int   ok_count = 0;
    int   err_count = 0;
    int   wr_base, ok_base, err_base;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .HEADER(8'hAA),
        .TIMEOUT_CYC(T),
        .BAUD_DEFAULT(3'd4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge Clk) begin
        if (bus.Reg_wr_en === 1'b1) wr_count++;
        if (bus.Frame_ok === 1'b1)  ok_count++;
        if (bus.Frame_err === 1'b1) err_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Called at a negedge; Rx_Done is high for the following cycle.
    task automatic send_byte(input logic [7:0] b);
        bus.Rx_Data = b;
        bus.Rx_Done = 1'b1;
        @(negedge Clk);
        bus.Rx_Done = 1'b0;
        bus.Rx_Data = 8'hAA;
    endtask

    // Returns in cycle N+1, N being the CHK byte cycle.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k, input int g);
        send_byte(8'hAA); gap(g);
        send_byte(c);     gap(g);
        send_byte(a);     gap(g);
        send_byte(d);     gap(g);
        send_byte(k);
    endtask

    task automatic check_reset_vals(input string where);
        check({where, " baud"},  32'(bus.Baud_set),  32'd4);
        check({where, " wr_en"}, 32'(bus.Reg_wr_en), 32'd0);
        check({where, " ok"},    32'(bus.Frame_ok),  32'd0);
        check({where, " err"},   32'(bus.Frame_err), 32'd0);
        check({where, " addr"},  32'(bus.Reg_addr),  32'd0);
        check({where, " wdata"}, 32'(bus.Reg_wdata), 32'd0);
        check({where, " cnt"},   32'(bus.Frame_cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d, k;
        Reset = 1'b1;
        bus.Rx_Done = 1'b0;
        bus.Rx_Data = 8'h00;
        gap(3);
        check_reset_vals("in_reset");
        Reset = 1'b0;
        gap(2);
        check_reset_vals("after_reset");

        // Write frame
        send_frame(8'h01, 8'h10, 8'h5A, 8'h6B, 2);
        check("wr N+1 wr_en", 32'(bus.Reg_wr_en), 32'd0);
        gap(1);
        check("wr N+2 wr_en", 32'(bus.Reg_wr_en), 32'd1);
        check("wr N+2 ok",    32'(bus.Frame_ok),  32'd1);
        check("wr N+2 err",   32'(bus.Frame_err), 32'd0);
        check("wr addr",      32'(bus.Reg_addr),  32'h10);
        check("wr wdata",     32'(bus.Reg_wdata), 32'h5A);
        check("wr cnt",       32'(bus.Frame_cnt), 32'd1);
        gap(1);
        check("wr N+3 wr_en", 32'(bus.Reg_wr_en), 32'd0);
        check("wr N+3 ok",    32'(bus.Frame_ok),  32'd0);
        gap(1);
        check("wr pulses", 32'(wr_count), 32'd1);
        check("wr oks",    32'(ok_count), 32'd1);
        check("wr errs",   32'(err_count), 32'd0);

        // Baud change 4 -> 3, then illegal baud 7
        send_frame(8'h02, 8'h00, 8'h03, 8'h05, 2);
        check("baud N+1", 32'(bus.Baud_set), 32'd4);
        gap(1);
        check("baud N+2",    32'(bus.Baud_set),  32'd3);
        check("baud ok",     32'(bus.Frame_ok),  32'd1);
        check("baud cnt",    32'(bus.Frame_cnt), 32'd2);
        check("baud no wr",  32'(bus.Reg_wr_en), 32'd0);
        gap(2);
        send_frame(8'h02, 8'h00, 8'h07, 8'h09, 2);
        gap(1);
        check("badbaud err",  32'(bus.Frame_err), 32'd1);
        check("badbaud ok",   32'(bus.Frame_ok),  32'd0);
        check("badbaud baud", 32'(bus.Baud_set),  32'd3);
        check("badbaud cnt",  32'(bus.Frame_cnt), 32'd2);
        gap(2);

        // Bad checksum
        wr_base = wr_count;
        send_frame(8'h01, 8'h10, 8'h5A, 8'h00, 2);
        check("badchk N+1 err", 32'(bus.Frame_err), 32'd1);
        gap(1);
        check("badchk N+2 err", 32'(bus.Frame_err), 32'd0);
        check("badchk N+2 wr",  32'(bus.Reg_wr_en), 32'd0);
        gap(2);
        check("badchk no wr", 32'(wr_count), 32'(wr_base));

        // Unknown command
        send_frame(8'h03, 8'h00, 8'h00, 8'h03, 2);
        check("unk N+1 err", 32'(bus.Frame_err), 32'd0);
        gap(1);
        check("unk N+2 err", 32'(bus.Frame_err), 32'd1);
        check("unk cnt",     32'(bus.Frame_cnt), 32'd2);
        gap(2);

        // Checksum wrap 0x1FF -> 0xFF
        send_frame(8'h01, 8'hFF, 8'hFF, 8'hFF, 2);
        gap(1);
        check("wrap wr",    32'(bus.Reg_wr_en), 32'd1);
        check("wrap addr",  32'(bus.Reg_addr),  32'hFF);
        check("wrap wdata", 32'(bus.Reg_wdata), 32'hFF);
        check("wrap cnt",   32'(bus.Frame_cnt), 32'd3);
        gap(2);

        // Noise then timeout
        err_base = err_count;
        send_byte(8'h55); gap(2);
        send_byte(8'h13); gap(2);
        check("noise no err", 32'(err_count), 32'(err_base));
        send_byte(8'hAA); gap(2);
        send_byte(8'h01); gap(2);
        send_byte(8'h10);
        gap(T - 1);
        check("tmo M+T err",   32'(bus.Frame_err), 32'd0);
        gap(1);
        check("tmo M+T+1 err", 32'(bus.Frame_err), 32'd1);
        gap(1);
        check("tmo M+T+2 err", 32'(bus.Frame_err), 32'd0);
        check("tmo single",    32'(err_count), 32'(err_base + 1));
        gap(2);
        send_frame(8'h01, 8'h20, 8'h33, 8'h54, 2);
        gap(1);
        check("post tmo wr",    32'(bus.Reg_wr_en), 32'd1);
        check("post tmo addr",  32'(bus.Reg_addr),  32'h20);
        check("post tmo wdata", 32'(bus.Reg_wdata), 32'h33);
        check("post tmo cnt",   32'(bus.Frame_cnt), 32'd4);
        gap(2);

        // Bytes landing exactly on the expiry cycle
        err_base = err_count;
        send_byte(8'hAA); gap(T - 1);
        send_byte(8'h01); gap(T - 1);
        send_byte(8'h10);
        check("expiry byte err", 32'(bus.Frame_err), 32'd0);
        gap(T - 1);
        send_byte(8'h5A); gap(T - 1);
        send_byte(8'h6B);
        gap(1);
        check("expiry wr",    32'(bus.Reg_wr_en), 32'd1);
        check("expiry wdata", 32'(bus.Reg_wdata), 32'h5A);
        check("expiry cnt",   32'(bus.Frame_cnt), 32'd5);
        gap(2);
        check("expiry no err", 32'(err_count), 32'(err_base));

        // Reset mid-frame
        send_byte(8'hAA); gap(2);
        send_byte(8'h01); gap(2);
        Reset = 1'b1;
        gap(2);
        Reset = 1'b0;
        check_reset_vals("midreset");
        wr_base = wr_count; ok_base = ok_count; err_base = err_count;
        send_byte(8'h10); gap(2);
        send_byte(8'h5A); gap(2);
        send_byte(8'h6B); gap(4);
        check("midreset wr",  32'(wr_count),  32'(wr_base));
        check("midreset ok",  32'(ok_count),  32'(ok_base));
        check("midreset err", 32'(err_count), 32'(err_base));
        send_frame(8'h01, 8'h10, 8'h5A, 8'h6B, 2);
        gap(1);
        check("midreset next wr",  32'(bus.Reg_wr_en), 32'd1);
        check("midreset next cnt", 32'(bus.Frame_cnt), 32'd1);
        gap(2);

        // 256 frames wrap the counter
        Reset = 1'b1;
        gap(2);
        Reset = 1'b0;
        ok_base = ok_count;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            d = a ^ 8'h3C;
            k = 8'h01 + a + d;
            send_frame(8'h01, a, d, k, 1);
            gap(2);
            if (i == 254) check("cnt at 255", 32'(bus.Frame_cnt), 32'd255);
        end
        check("cnt wrapped",   32'(bus.Frame_cnt), 32'd0);
        check("256 ok pulses", 32'(ok_count - ok_base), 32'd256);
        check("last addr",     32'(bus.Reg_addr),  32'hFF);
        check("last wdata",    32'(bus.Reg_wdata), 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
